a2d_pot_scanner: RTL and testbench
==================================

// Module: a2d_pot_scanner
// PURPOSE
//  Sequences the SPI A2D interface. Round-robins channels 0..NUM_CH-1 (band-gain/volume pots).
//  Holds the latest 12-bit result per channel in a register bank.
//  Also serves one external single-shot requester, which has priority over the next scan slot.
//  Sits between the A2D interface (strt_cnv/chnnl/cnv_cmplt/res) and the EQ gain logic.
// PARAMETERS
//  NUM_CH    7    channels scanned, 1..8, mapped to A2D channel index 0..NUM_CH-1
//  SCAN_GAP  16   idle clk cycles between the end of one conversion and the next scan start, >=1
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous reset, active-high
//  en         in   1          scan enable (level)
//  req        in   1          external conversion request (level, held until req_ack)
//  req_ch     in   3          channel for the external request
//  req_ack    out  1          1-cycle pulse: request done, req_res valid that cycle
//  req_res    out  12         result of the external request (held until the next req_ack)
//  strt_cnv   out  1          1-cycle start pulse to the A2D interface
//  chnnl      out  3          channel to the A2D interface, stable from strt_cnv until the conversion completes
//  cnv_cmplt  in   1          A2D done; level-latched, cleared by the A2D after strt_cnv
//  res        in   12         A2D result, valid while cnv_cmplt=1
//  pots       out  NUM_CH*12  result bank; channel n occupies bits [n*12+:12]
//  pot_vld    out  NUM_CH     bit n set once channel n has been written at least once
//  scan_done  out  1          1-cycle pulse when channel NUM_CH-1 is written by the scan
// BEHAVIOUR
//  Reset values: all outputs 0; bank 0; scan pointer 0; gap counter 0; state IDLE.
//  States:
//   IDLE  -> START if req | en. The gap counter is loaded with SCAN_GAP on entry to GAP.
//   GAP   counter decrements each cycle.
//         -> START immediately if req.
//         -> START when counter==0 and en.
//         -> IDLE when counter==0 and !en.
//   START strt_cnv=1 for exactly 1 cycle; captures source (REQ if req, else SCAN) and chnnl -> CONV.
//   CONV  waits for a rising edge of cnv_cmplt (registered previous value; a stale high level is ignored).
//         On the edge it writes the result. Then -> GAP, with the counter reloaded.
//  Arbitration: req always wins a START slot. The scan pointer does not advance on request conversions.
//  SCAN write: pots[ptr]<=res, pot_vld[ptr]<=1. ptr wraps NUM_CH-1 -> 0, with scan_done that cycle.
//  REQ write:
//   - req_res<=res and req_ack=1 in the edge cycle.
//   - If req_ch<NUM_CH, the bank entry and vld bit are also updated.
//   - If req_ch>=NUM_CH, the conversion still runs and is acked, with no bank write.
//  Latency: strt_cnv is asserted 1 cycle after req is seen in IDLE/GAP.
//           req_ack is asserted on the cycle the cnv_cmplt edge is sampled.
//  en deasserted mid-conversion: the in-flight conversion completes and is written, then GAP -> IDLE.
//  req and scan slot due in the same cycle: req is served and the scan slot is deferred to the next START.
//  req dropped before START is sampled: ignored. A request dropped after START is still acked.
//  rst mid-operation: everything returns to reset values at once. The top level resets the A2D from the same rst.
//  chnnl holds its last value outside CONV; it is only required to be valid from START through CONV.
// CONFIGURATION
//  POT_AVG_EN defined:
//   - A bank write to an entry whose vld bit is already 1 stores (old+res+1)>>1, using a 13-bit sum.
//   - A first write, or an entry with vld=0, stores res directly.
//   - req_res is always raw res.
//  POT_AVG_EN undefined: bank stores raw res; no adder synthesized.
// STRUCTURE
//  Package a2d_sched_pkg: ADC_W=12, CH_W=3, state enum {IDLE,GAP,START,CONV}, source enum {SRC_SCAN,SRC_REQ}.
//  No sub-module needed. The averaging is a function in the package, used only under POT_AVG_EN.
// TESTING (A2D modelled by a BFM: fixed 40-cycle conversion, returns res = 12'h100+ch)
//  1. rst; en=1, NUM_CH=7, SCAN_GAP=16 -> strt_cnv with chnnl 0..6 in order.
//     pots[n]=0x100+n, pot_vld=7'h7F, and one scan_done after ch6; the next scan restarts at ch0.
//  2. Mid-gap after ch2 written, req=1, req_ch=5 -> next strt_cnv has chnnl=5 and req_ack with req_res=0x105.
//     The following scan conversion is ch3.
//  3. req_ch=7 (NUM_CH=7) -> conversion runs, req_ack with req_res=0x107, pots and pot_vld unchanged.
//  4. Drop en during the ch4 conversion -> pots[4] is written, then IDLE after the gap with no further strt_cnv.
//     Re-assert en -> scan resumes at ch5.
//  5. POT_AVG_EN defined, BFM returns 0x200 then 0x301 on ch0 -> pots[0]=0x200 then 0x281.
//  6. Assert rst during CONV -> all outputs 0 asynchronously; after release with en=1, the first strt_cnv has chnnl=0.

Source files
------------

// File: rtl/a2d_sched_pkg.sv
// Shared types and widths for the A2D pot scanner.
// Optional feature macro: POT_AVG_EN (enables the pot_avg helper used for bank averaging).
package a2d_sched_pkg;

   localparam int unsigned ADC_W = 12;
   localparam int unsigned CH_W  = 3;
   localparam int unsigned SUM_W = ADC_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      START = 2'd2,
      CONV  = 2'd3
   } state_e;

   typedef enum logic {
      SRC_SCAN = 1'b0,
      SRC_REQ  = 1'b1
   } src_e;

`ifdef POT_AVG_EN
   // Rounded mean of the stored and new sample, carried in a 13-bit sum
   function automatic logic [ADC_W-1:0] pot_avg(input logic [ADC_W-1:0] old_v,
                                                input logic [ADC_W-1:0] new_v);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(old_v) + SUM_W'(new_v) + SUM_W'(1);
      return sum[SUM_W-1:1];
   endfunction
`endif

endpackage

// File: rtl/a2d_pot_scanner.sv
// Round-robin pot scanner in front of the SPI A2D, with one priority single-shot requester.
// Optional feature macro: POT_AVG_EN (bank writes to valid entries store a rounded average).
module a2d_pot_scanner
   import a2d_sched_pkg::*;
#(
   parameter int unsigned NUM_CH   = 7,
   parameter int unsigned SCAN_GAP = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     req,
   input  logic [CH_W-1:0]          req_ch,
   output logic                     req_ack,
   output logic [ADC_W-1:0]         req_res,
   output logic                     strt_cnv,
   output logic [CH_W-1:0]          chnnl,
   input  logic                     cnv_cmplt,
   input  logic [ADC_W-1:0]         res,
   output logic [NUM_CH*ADC_W-1:0]  pots,
   output logic [NUM_CH-1:0]        pot_vld,
   output logic                     scan_done
);

   localparam int unsigned GAP_W  = $clog2(SCAN_GAP + 1);
   localparam int unsigned BANK_W = NUM_CH * ADC_W;

   state_e                state_q, state_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [CH_W-1:0]       ptr_q, ptr_d;
   src_e                  src_q, src_d;
   logic [CH_W-1:0]       chnnl_q, chnnl_d;
   logic                  cmplt_q, cmplt_d;
   logic                  strt_q, strt_d;
   logic                  ack_q, ack_d;
   logic [ADC_W-1:0]      req_res_q, req_res_d;
   logic [BANK_W-1:0]     pots_q, pots_d;
   logic [NUM_CH-1:0]     vld_q, vld_d;
   logic                  done_q, done_d;

   logic                  cmplt_rise_c;
   logic                  wr_c;
   logic [CH_W-1:0]       wr_idx_c;

   // Only a fresh rising edge of the A2D done level counts; a stale high is ignored
   assign cmplt_rise_c = cnv_cmplt & ~cmplt_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: request always claims the next start slot
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (req || en) state_d = START;
         GAP: begin
            if (req)               state_d = START;
            else if (gap_q == '0)  state_d = en ? START : IDLE;
         end
         START: state_d = CONV;
         CONV:  if (cmplt_rise_c) state_d = GAP;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values: start pulse, source capture, gap count, bank writes
   always_comb begin
      gap_d     = gap_q;
      ptr_d     = ptr_q;
      src_d     = src_q;
      chnnl_d   = chnnl_q;
      cmplt_d   = cnv_cmplt;
      strt_d    = 1'b0;
      ack_d     = 1'b0;
      req_res_d = req_res_q;
      pots_d    = pots_q;
      vld_d     = vld_q;
      done_d    = 1'b0;
      wr_c      = 1'b0;
      wr_idx_c  = ptr_q;

      if ((state_q == IDLE || state_q == GAP) && state_d == START) begin
         strt_d = 1'b1;
         if (req) begin
            src_d   = SRC_REQ;
            chnnl_d = req_ch;
         end else begin
            src_d   = SRC_SCAN;
            chnnl_d = ptr_q;
         end
      end

      if (state_q == GAP && gap_q != '0)
         gap_d = gap_q - GAP_W'(1);

      if (state_q == CONV && cmplt_rise_c) begin
         gap_d = GAP_W'(SCAN_GAP);
         if (src_q == SRC_REQ) begin
            ack_d     = 1'b1;
            req_res_d = res;
            wr_idx_c  = chnnl_q;
            wr_c      = ({1'b0, chnnl_q} < (CH_W+1)'(NUM_CH));
         end else begin
            wr_c     = 1'b1;
            wr_idx_c = ptr_q;
            if (ptr_q == CH_W'(NUM_CH - 1)) begin
               ptr_d  = '0;
               done_d = 1'b1;
            end else begin
               ptr_d = ptr_q + CH_W'(1);
            end
         end
      end

      for (int n = 0; n < NUM_CH; n++) begin
         if (wr_c && wr_idx_c == CH_W'(n)) begin
`ifdef POT_AVG_EN
            pots_d[n*ADC_W +: ADC_W] = vld_q[n] ? pot_avg(pots_q[n*ADC_W +: ADC_W], res) : res;
`else
            pots_d[n*ADC_W +: ADC_W] = res;
`endif
            vld_d[n] = 1'b1;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_q     <= '0;
         ptr_q     <= '0;
         src_q     <= SRC_SCAN;
         chnnl_q   <= '0;
         cmplt_q   <= 1'b0;
         strt_q    <= 1'b0;
         ack_q     <= 1'b0;
         req_res_q <= '0;
         pots_q    <= '0;
         vld_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         gap_q     <= gap_d;
         ptr_q     <= ptr_d;
         src_q     <= src_d;
         chnnl_q   <= chnnl_d;
         cmplt_q   <= cmplt_d;
         strt_q    <= strt_d;
         ack_q     <= ack_d;
         req_res_q <= req_res_d;
         pots_q    <= pots_d;
         vld_q     <= vld_d;
         done_q    <= done_d;
      end
   end

   assign strt_cnv  = strt_q;
   assign chnnl     = chnnl_q;
   assign req_ack   = ack_q;
   assign req_res   = req_res_q;
   assign pots      = pots_q;
   assign pot_vld   = vld_q;
   assign scan_done = done_q;

endmodule

// File: tb/tb_a2d_pot_scanner.sv
// Scoreboard bench for a2d_pot_scanner with a 40-cycle A2D model.
// Honours POT_AVG_EN for the expected bank contents.
module tb_a2d_pot_scanner;

   localparam int unsigned NUM_CH = 7;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  en = 1'b0;
   logic                  req = 1'b0;
   logic [2:0]            req_ch = 3'd0;
   logic                  req_ack;
   logic [11:0]           req_res;
   logic                  strt_cnv;
   logic [2:0]            chnnl;
   logic                  cnv_cmplt;
   logic [11:0]           res;
   logic [NUM_CH*12-1:0]  pots;
   logic [NUM_CH-1:0]     pot_vld;
   logic                  scan_done;

   a2d_pot_scanner #(.NUM_CH(NUM_CH), .SCAN_GAP(16)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .req_ch(req_ch),
      .req_ack(req_ack), .req_res(req_res), .strt_cnv(strt_cnv), .chnnl(chnnl),
      .cnv_cmplt(cnv_cmplt), .res(res), .pots(pots), .pot_vld(pot_vld),
      .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int strt_cnt = 0;
   int ack_cnt = 0;
   int done_cnt = 0;
   logic [2:0]  exp_ch[$];
   logic [11:0] exp_ack[$];

   // A2D model controls
   logic [11:0] ofs = 12'h000;
   logic        ovr_en = 1'b0;
   logic [11:0] ch0_val = 12'h000;
   logic        bfm_busy;
   logic [5:0]  bfm_cnt;
   logic [2:0]  bfm_ch;

   function automatic logic [11:0] bfm_val(input logic [2:0] ch);
      if (ovr_en && ch == 3'd0) return ch0_val;
      return 12'h100 + 12'(ch) + ofs;
   endfunction

   function automatic logic [11:0] bank_exp(input logic [11:0] old_v, input logic [11:0] new_v);
`ifdef POT_AVG_EN
      logic [12:0] s;
      s = 13'(old_v) + 13'(new_v) + 13'd1;
      return s[12:1];
`else
      return new_v + 12'(0 * old_v);
`endif
   endfunction

   function automatic logic [11:0] pot(input int n);
      return pots[n*12 +: 12];
   endfunction

   // A2D model: clears done after start, raises it with the result 40 cycles later
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnv_cmplt <= 1'b0;
         res       <= 12'h000;
         bfm_busy  <= 1'b0;
         bfm_cnt   <= 6'd0;
         bfm_ch    <= 3'd0;
      end else if (strt_cnv) begin
         cnv_cmplt <= 1'b0;
         bfm_busy  <= 1'b1;
         bfm_cnt   <= 6'd40;
         bfm_ch    <= chnnl;
      end else if (bfm_busy) begin
         if (bfm_cnt == 6'd1) begin
            cnv_cmplt <= 1'b1;
            res       <= bfm_val(bfm_ch);
            bfm_busy  <= 1'b0;
         end
         bfm_cnt <= bfm_cnt - 6'd1;
      end
   end

   // Monitor: pops expected start channels and request results as the DUT presents them
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (strt_cnv) begin
            strt_cnt++;
            total++;
            if (exp_ch.size() == 0) begin
               bad++;
               $display("FAIL strt_chnnl: unexpected start on ch %0d", chnnl);
            end else begin
               logic [2:0] e;
               e = exp_ch.pop_front();
               if (chnnl !== e) begin
                  bad++;
                  $display("FAIL strt_chnnl: got %0d want %0d", chnnl, e);
               end
            end
         end
         if (req_ack) begin
            ack_cnt++;
            total++;
            if (exp_ack.size() == 0) begin
               bad++;
               $display("FAIL req_ack: unexpected ack res %h", req_res);
            end else begin
               logic [11:0] e;
               e = exp_ack.pop_front();
               if (req_res !== e) begin
                  bad++;
                  $display("FAIL req_res: got %h want %h", req_res, e);
               end
            end
         end
         if (scan_done) done_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_strt(input int target, input string nm);
      int n = 0;
      while (strt_cnt < target && n < 400) begin @(negedge clk); n++; end
      chk(nm, 32'(strt_cnt >= target), 32'd1);
   endtask

   task automatic wait_ack(input int target, input string nm);
      int n = 0;
      while (ack_cnt < target && n < 400) begin @(negedge clk); n++; end
      chk(nm, 32'(ack_cnt >= target), 32'd1);
   endtask

   task automatic wait_done(input int target, input string nm);
      int n = 0;
      while (done_cnt < target && n < 1000) begin @(negedge clk); n++; end
      chk(nm, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_pots_lo"}, pots[31:0], 32'd0);
      chk({nm, "_pots_all"}, 32'(pots != '0), 32'd0);
      chk({nm, "_vld"}, 32'(pot_vld), 32'd0);
      chk({nm, "_ctl"}, 32'({strt_cnv, req_ack, scan_done, chnnl, req_res}), 32'd0);
   endtask

   logic [NUM_CH*12-1:0] snap_pots;
   logic [11:0] e4, e5, e6;

   initial begin
      // Reset state
      cycles(3);
      chk_zero("reset");
      rst = 1'b0;
      cycles(2);

      // 1: full scan round, ch0..6, then restart at ch0
      for (int i = 0; i < 7; i++) exp_ch.push_back(3'(i));
      exp_ch.push_back(3'd0); exp_ch.push_back(3'd1); exp_ch.push_back(3'd2);
      en = 1'b1;
      wait_done(1, "scan_done_round1");
      for (int i = 0; i < 7; i++) chk($sformatf("pot%0d_r1", i), 32'(pot(i)), 32'h100 + 32'(i));
      chk("vld_r1", 32'(pot_vld), 32'h7F);

      // 2: request in the gap after ch2 beats the ch3 scan slot
      wait_strt(10, "wait_ch2");
      cycles(45);
      chk("done_once", 32'(done_cnt), 32'd1);
      req_ch = 3'd5; req = 1'b1;
      exp_ch.push_back(3'd5); exp_ack.push_back(12'h105);
      exp_ch.push_back(3'd3);
      wait_ack(1, "ack_ch5");
      req = 1'b0;

      // 3: out-of-range request channel is converted and acked without a bank write
      wait_strt(12, "wait_ch3");
      cycles(45);
      snap_pots = pots;
      req_ch = 3'd7; req = 1'b1;
      exp_ch.push_back(3'd7); exp_ack.push_back(12'h107);
      wait_ack(2, "ack_ch7");
      req = 1'b0;
      total++;
      if (pots !== snap_pots) begin
         bad++;
         $display("FAIL bank_ch7: got %h want %h", pots, snap_pots);
      end
      chk("vld_ch7", 32'(pot_vld), 32'h7F);

      // 4: drop en during ch4, bank still written, then idle; resume at ch5
      exp_ch.push_back(3'd4);
      wait_strt(14, "wait_ch4");
      ofs = 12'h020;
      cycles(5);
      en = 1'b0;
      cycles(150);
      chk("idle_no_strt", 32'(strt_cnt), 32'd14);
      e4 = bank_exp(12'h104, 12'h124);
      chk("pot4_en_drop", 32'(pot(4)), 32'(e4));
      exp_ch.push_back(3'd5); exp_ch.push_back(3'd6); exp_ch.push_back(3'd0);
      en = 1'b1;
      wait_strt(17, "wait_resume");
      e5 = bank_exp(12'h105, 12'h125);
      e6 = bank_exp(12'h106, 12'h126);
      chk("pot5_resume", 32'(pot(5)), 32'(e5));
      chk("pot6_resume", 32'(pot(6)), 32'(e6));
      chk("done_round2", 32'(done_cnt), 32'd2);

      // 6: reset during a conversion clears everything immediately
      cycles(5);
      rst = 1'b1;
      #1;
      chk_zero("rst_conv");
      exp_ch.delete();
      exp_ack.delete();
      ofs = 12'h000; ovr_en = 1'b1; ch0_val = 12'h200;
      cycles(2);
      rst = 1'b0;

      // 5: ch0 first write raw, second write averaged when enabled
      for (int i = 0; i < 7; i++) exp_ch.push_back(3'(i));
      exp_ch.push_back(3'd0);
      wait_strt(19, "wait_post_rst");
      chk("pot0_first", 32'(pot(0)), 32'h200);
      chk("vld_first", 32'(pot_vld), 32'h01);
      ch0_val = 12'h301;
      wait_strt(25, "wait_ch0_again");
      cycles(45);
`ifdef POT_AVG_EN
      chk("pot0_second", 32'(pot(0)), 32'h281);
`else
      chk("pot0_second", 32'(pot(0)), 32'h301);
`endif
      chk("done_round3", 32'(done_cnt), 32'd3);
      chk("exp_left", 32'(exp_ch.size() + exp_ack.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
